// File: rtl/sprite_pkg.sv
// Shared constants and types for the yellow crewmate sprite fetch path.
package sprite_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned PAL_W    = 3;

    localparam logic [PAL_W-1:0] TRANSPARENT_IDX = '0;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } anim_state_t;

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Frame-synchronous position latch and walk-cycle animation controller.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned FRAMES       = 4,
    parameter int unsigned FRAME_PERIOD = 8,
    localparam int unsigned FW          = $clog2(FRAMES),
    localparam int unsigned CW          = $clog2(FRAME_PERIOD)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_frame_start,
    input  logic [COORD_W-1:0] i_sprite_x,
    input  logic [COORD_W-1:0] i_sprite_y,
    input  logic               i_facing_left,
    input  logic               i_walking,
    output logic [COORD_W-1:0] o_sx,
    output logic [COORD_W-1:0] o_sy,
    output logic               o_facing,
    output logic               o_valid,
    output logic [FW-1:0]      o_frame
);

    anim_state_t   r_state;
    anim_state_t   w_state_nxt;
    logic [FW-1:0] r_frame;
    logic [FW-1:0] w_frame_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // Shadow copy of position/facing; o_valid marks that a frame has been latched since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sx     <= '0;
            o_sy     <= '0;
            o_facing <= 1'b0;
            o_valid  <= 1'b0;
        end else if (i_frame_start) begin
            o_sx     <= i_sprite_x;
            o_sy     <= i_sprite_y;
            o_facing <= i_facing_left;
            o_valid  <= 1'b1;
        end
    end

    // Animation state, frame index and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_frame <= w_frame_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; only frame_start cycles can move the animation.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_cnt_nxt   = r_cnt;
        if (i_frame_start) begin
            case (r_state)
                IDLE: begin
                    w_frame_nxt = '0;
                    w_cnt_nxt   = '0;
                    if (i_walking) begin
                        w_state_nxt = WALK;
                    end
                end
                WALK: begin
                    if (!i_walking) begin
                        w_state_nxt = IDLE;
                        w_frame_nxt = '0;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CW'(FRAME_PERIOD - 1)) begin
                        w_cnt_nxt   = '0;
                        w_frame_nxt = r_frame + FW'(1);
                    end else begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_frame_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_frame = r_frame;

endmodule

// File: rtl/yellow_sprite_fetch.sv
// Per-pixel sprite ROM address generation and palette index pipeline (2-Clk latency).
module yellow_sprite_fetch
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W     = 32,
    parameter int unsigned SPRITE_H     = 32,
    parameter int unsigned FRAMES       = 4,
    parameter int unsigned FRAME_PERIOD = 8,
    parameter int unsigned ADDR_W       = $clog2(SPRITE_W * SPRITE_H * FRAMES)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [COORD_W-1:0] SpriteX,
    input  logic [COORD_W-1:0] SpriteY,
    input  logic               facing_left,
    input  logic               walking,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [PAL_W-1:0]   rom_data,
    output logic [PAL_W-1:0]   select_output,
    output logic               sprite_on
);

    localparam int unsigned XW = $clog2(SPRITE_W);
    localparam int unsigned YW = $clog2(SPRITE_H);
    localparam int unsigned FW = $clog2(FRAMES);
    localparam int unsigned DW = COORD_W + 1;

    logic [COORD_W-1:0] w_sx;
    logic [COORD_W-1:0] w_sy;
    logic               w_facing;
    logic               w_valid;
    logic [FW-1:0]      w_frame;
    logic [DW-1:0]      w_dx;
    logic [DW-1:0]      w_dy;
    logic               w_in_box;
    logic [XW-1:0]      w_col;
    logic [ADDR_W-1:0]  w_addr;
    logic               r_in_box_d;

    sprite_anim_ctrl #(
        .FRAMES       (FRAMES),
        .FRAME_PERIOD (FRAME_PERIOD)
    ) u_anim (
        .clk           (Clk),
        .rst_n         (Reset_n),
        .i_frame_start (frame_start),
        .i_sprite_x    (SpriteX),
        .i_sprite_y    (SpriteY),
        .i_facing_left (facing_left),
        .i_walking     (walking),
        .o_sx          (w_sx),
        .o_sy          (w_sy),
        .o_facing      (w_facing),
        .o_valid       (w_valid),
        .o_frame       (w_frame)
    );

    // Wrap-around offsets: pixels left of / above the sprite become huge and fall outside the box.
    always_comb begin
        w_dx     = {1'b0, DrawX} - {1'b0, w_sx};
        w_dy     = {1'b0, DrawY} - {1'b0, w_sy};
        w_in_box = w_valid && (w_dx < DW'(SPRITE_W)) && (w_dy < DW'(SPRITE_H));
        w_col    = w_facing ? (XW'(SPRITE_W - 1) - w_dx[XW-1:0]) : w_dx[XW-1:0];
        w_addr   = w_in_box ? {w_frame, w_dy[YW-1:0], w_col} : '0;
    end

    // Stage 1: ROM address and in-box flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr   <= '0;
            r_in_box_d <= 1'b0;
        end else begin
            rom_addr   <= w_addr;
            r_in_box_d <= w_in_box;
        end
    end

    // Stage 2: palette index from ROM, transparent outside the sprite box.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            select_output <= TRANSPARENT_IDX;
            sprite_on     <= 1'b0;
        end else begin
            select_output <= r_in_box_d ? rom_data : TRANSPARENT_IDX;
            sprite_on     <= r_in_box_d && (rom_data != TRANSPARENT_IDX);
        end
    end

endmodule

// File: tb/tb_yellow_sprite_fetch.sv
// Directed self-checking bench for yellow_sprite_fetch.
module tb_yellow_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  SpriteX;
    logic [9:0]  SpriteY;
    logic        facing_left;
    logic        walking;
    logic [11:0] rom_addr;
    logic [2:0]  rom_data;
    logic [2:0]  select_output;
    logic        sprite_on;

    int total = 0;
    int bad   = 0;

    yellow_sprite_fetch dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_start   (frame_start),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .SpriteX       (SpriteX),
        .SpriteY       (SpriteY),
        .facing_left   (facing_left),
        .walking       (walking),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .select_output (select_output),
        .sprite_on     (sprite_on)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [9:0] sx, input logic [9:0] sy, input logic f, input logic w);
        SpriteX     = sx;
        SpriteY     = sy;
        facing_left = f;
        walking     = w;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic px(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        tick();
    endtask

    initial begin
        logic [15:0] acc;
        Reset_n = 1'b0; frame_start = 1'b0; DrawX = '0; DrawY = '0;
        SpriteX = '0; SpriteY = '0; facing_left = 1'b0; walking = 1'b0; rom_data = 3'd7;

        // reset held for 3 clocks
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_sel", 32'(select_output), 32'd0);
        chk("rst_on", 32'(sprite_on), 32'd0);
        Reset_n = 1'b1;

        // raster sweep with no frame_start: nothing may draw
        acc = '0;
        for (int y = 0; y < 480; y += 16) begin
            for (int x = 0; x < 640; x += 4) begin
                px(10'(x), 10'(y));
                acc |= {rom_addr, select_output, sprite_on};
            end
        end
        chk("raster_idle", 32'(acc), 32'd0);

        // basic placement, not mirrored
        pulse(10'd100, 10'd50, 1'b0, 1'b0);
        px(10'd100, 10'd50);
        chk("tl_addr", 32'(rom_addr), 32'd0);
        rom_data = 3'd3; tick();
        chk("tl_sel", 32'(select_output), 32'd3);
        chk("tl_on", 32'(sprite_on), 32'd1);
        px(10'd131, 10'd81);
        chk("br_addr", 32'(rom_addr), 32'd1023);
        rom_data = 3'd5; tick();
        chk("br_sel", 32'(select_output), 32'd5);
        px(10'd132, 10'd81);
        chk("right_out_addr", 32'(rom_addr), 32'd0);
        rom_data = 3'd6; tick();
        chk("right_out_sel", 32'(select_output), 32'd0);
        chk("right_out_on", 32'(sprite_on), 32'd0);
        px(10'd99, 10'd50);
        rom_data = 3'd6; tick();
        chk("left_out_sel", 32'(select_output), 32'd0);

        // mirrored
        pulse(10'd100, 10'd50, 1'b1, 1'b0);
        px(10'd100, 10'd50);
        chk("mir_addr", 32'(rom_addr), 32'd31);
        rom_data = 3'd4; tick();
        chk("mir_sel4", 32'(select_output), 32'd4);
        chk("mir_on4", 32'(sprite_on), 32'd1);
        rom_data = 3'd0; tick();
        chk("mir_sel0", 32'(select_output), 32'd0);
        chk("mir_on0", 32'(sprite_on), 32'd0);
        px(10'd131, 10'd50);
        chk("mir_right_addr", 32'(rom_addr), 32'd0);
        px(10'd100, 10'd51);
        chk("mir_row1_addr", 32'(rom_addr), 32'd63);

        // walk cycle: frame 0 for pulses 1..8, then 1, 2, 3, back to 0 at pulse 33
        for (int k = 1; k <= 33; k++) begin
            int fr;
            fr = ((k - 1) / 8) % 4;
            pulse(10'd100, 10'd50, 1'b0, 1'b1);
            px(10'd100, 10'd50);
            chk("walk_addr", 32'(rom_addr), 32'(1024 * fr));
        end

        // 16 more pulses reach frame 2
        repeat (16) pulse(10'd100, 10'd50, 1'b0, 1'b1);
        px(10'd101, 10'd50);
        chk("walk_f2_addr", 32'(rom_addr), 32'd2049);
        pulse(10'd100, 10'd50, 1'b0, 1'b0);
        px(10'd101, 10'd50);
        chk("stop_addr", 32'(rom_addr), 32'd1);

        // SpriteX moves mid-frame: ignored until next frame_start
        SpriteX = 10'd200;
        px(10'd101, 10'd50);
        chk("midframe_addr", 32'(rom_addr), 32'd1);
        pulse(10'd200, 10'd50, 1'b0, 1'b0);
        px(10'd101, 10'd50);
        chk("newpos_old_addr", 32'(rom_addr), 32'd0);
        px(10'd201, 10'd50);
        chk("newpos_addr", 32'(rom_addr), 32'd1);

        // frame_start coinciding with an in-box pixel
        DrawX = 10'd201; DrawY = 10'd50;
        pulse(10'd300, 10'd50, 1'b0, 1'b0);
        chk("coincide_old", 32'(rom_addr), 32'd1);
        tick();
        chk("coincide_new", 32'(rom_addr), 32'd0);

        // bottom-right corner clipping
        pulse(10'd630, 10'd470, 1'b0, 1'b0);
        px(10'd639, 10'd479);
        chk("corner_addr", 32'(rom_addr), 32'd297);
        rom_data = 3'd7; tick();
        chk("corner_sel", 32'(select_output), 32'd7);
        px(10'd629, 10'd470);
        rom_data = 3'd7; tick();
        chk("corner_left_sel", 32'(select_output), 32'd0);
        px(10'd630, 10'd469);
        rom_data = 3'd7; tick();
        chk("corner_above_sel", 32'(select_output), 32'd0);

        // SX=5: no wrap to left edge
        pulse(10'd5, 10'd0, 1'b0, 1'b0);
        px(10'd0, 10'd0);
        rom_data = 3'd7; tick();
        chk("nowrap_sel", 32'(select_output), 32'd0);
        px(10'd36, 10'd0);
        chk("sx5_last_addr", 32'(rom_addr), 32'd31);
        px(10'd37, 10'd0);
        chk("sx5_out_addr", 32'(rom_addr), 32'd0);

        // SX beyond screen: nothing draws
        pulse(10'd700, 10'd0, 1'b0, 1'b0);
        px(10'd639, 10'd0);
        rom_data = 3'd7; tick();
        chk("offscreen_sel", 32'(select_output), 32'd0);

        // asynchronous reset mid-line
        pulse(10'd5, 10'd0, 1'b0, 1'b0);
        px(10'd6, 10'd0);
        chk("pre_rst_addr", 32'(rom_addr), 32'd1);
        rom_data = 3'd7; tick();
        chk("pre_rst_sel", 32'(select_output), 32'd7);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_addr", 32'(rom_addr), 32'd0);
        chk("async_rst_sel", 32'(select_output), 32'd0);
        chk("async_rst_on", 32'(sprite_on), 32'd0);
        tick();
        Reset_n = 1'b1;
        SpriteX = 10'd5;
        px(10'd6, 10'd0);
        rom_data = 3'd7; tick();
        chk("post_rst_addr", 32'(rom_addr), 32'd0);
        chk("post_rst_sel", 32'(select_output), 32'd0);
        pulse(10'd0, 10'd0, 1'b0, 1'b0);
        px(10'd3, 10'd0);
        chk("post_rst_latch_addr", 32'(rom_addr), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
